// File: rtl/byte_align.sv
// Serial sync-marker hunter and byte aligner for the deserializer front end.
// Optional inverted-stream detection is enabled by defining BYTE_ALIGN_POL_DET_EN.
module byte_align #(
    parameter logic [7:0]  SYNC_WORD   = 8'hA5,
    parameter int unsigned FRAME_BYTES = 4,
    parameter int unsigned LOCK_CNT    = 3,
    parameter int unsigned LOSS_CNT    = 2
) (
    input  logic       t_clk,
    input  logic       rst_n,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] sync_err_cnt,
    output logic       polarity
);

    localparam int unsigned BC_W  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] LOCK_TGT  = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] LOSS_TGT  = CNT_W'(LOSS_CNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [6:0]       sr_q, sr_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             fstart_q, fstart_d;
    logic             locked_q, locked_d;
    logic [7:0]       err_q, err_d;
    logic             pol_q, pol_d;

    logic [7:0] nsr;
    logic [7:0] cmp;
    logic       boundary;
    logic       marker_slot;
    logic       hunt_hit;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        byte_cnt_d = byte_cnt_q;
        good_d     = good_q;
        miss_d     = miss_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        fstart_d   = 1'b0;
        locked_d   = locked_q;
        err_d      = err_q;
        pol_d      = pol_q;
        hunt_hit   = 1'b0;

        nsr         = {sr_q, data_in};
        sr_d        = nsr[6:0];
        cmp         = pol_q ? ~nsr : nsr;
        boundary    = (bit_cnt_q == 3'd7);
        marker_slot = boundary && (byte_cnt_q == LAST_BYTE);

        if (boundary) begin
            byte_cnt_d = (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + BC_W'(1);
        end

        case (state_q)
            HUNT: begin
`ifdef BYTE_ALIGN_POL_DET_EN
                if (nsr == SYNC_WORD) begin
                    hunt_hit = 1'b1;
                    pol_d    = 1'b0;
                end else if (nsr == ~SYNC_WORD) begin
                    hunt_hit = 1'b1;
                    pol_d    = 1'b1;
                end
`else
                hunt_hit = (nsr == SYNC_WORD);
`endif
                if (hunt_hit) begin
                    state_d    = VERIFY;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = '0;
                    good_d     = CNT_W'(1);
                end
            end
            VERIFY: begin
                if (marker_slot) begin
                    if (cmp == SYNC_WORD) begin
                        good_d = good_q + CNT_W'(1);
                        if (good_q + CNT_W'(1) == LOCK_TGT) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            miss_d   = '0;
                        end
                    end else begin
                        state_d = HUNT;
                        good_d  = '0;
                    end
                end
            end
            LOCKED: begin
                if (marker_slot) begin
                    if (cmp == SYNC_WORD) begin
                        miss_d = '0;
                    end else begin
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        // Enough consecutive misses means the bit alignment is gone.
                        if (miss_q + CNT_W'(1) == LOSS_TGT) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            miss_d   = '0;
                        end else begin
                            miss_d = miss_q + CNT_W'(1);
                        end
                    end
                end else if (boundary) begin
                    data_d   = cmp;
                    valid_d  = 1'b1;
                    fstart_d = (byte_cnt_q == '0);
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            good_q     <= '0;
            miss_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fstart_q   <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= '0;
            pol_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            good_q     <= good_d;
            miss_q     <= miss_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fstart_q   <= fstart_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            pol_q      <= pol_d;
        end
    end

    assign data_out     = data_q;
    assign byte_valid   = valid_q;
    assign frame_start  = fstart_q;
    assign locked       = locked_q;
    assign sync_err_cnt = err_q;
    assign polarity     = pol_q;

endmodule
